// File: rtl/lcd_text_driver.sv
// HD44780 4-bit text driver: power-up init, config, then continuous refresh of a
// ROWS x COLS character buffer to the LCD.
module lcd_text_driver #(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned COLS     = 16,
   parameter int unsigned ROWS     = 2,
   parameter logic [2:0]  DISP_DCB = 3'b100,
   localparam int unsigned NCHR    = ROWS * COLS,
   localparam int unsigned AW      = (NCHR > 1) ? $clog2(NCHR) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          clr,
   output logic          ready,
   output logic          sf_e,
   output logic          lcd_e,
   output logic          lcd_rs,
   output logic          lcd_rw,
   output logic [3:0]    lcd_db
);

   function automatic int unsigned cyc_of(input longint unsigned hz, input longint unsigned ns);
      longint unsigned c;
      c = (hz * ns + 64'd999_999_999) / 64'd1_000_000_000;
      return (c == 0) ? 32'd1 : 32'(c);
   endfunction

   localparam int unsigned T_PWR  = cyc_of(CLK_HZ, 15_000_000);
   localparam int unsigned T_4M1  = cyc_of(CLK_HZ, 4_100_000);
   localparam int unsigned T_100U = cyc_of(CLK_HZ, 100_000);
   localparam int unsigned T_40U  = cyc_of(CLK_HZ, 40_000);
   localparam int unsigned T_CLR  = cyc_of(CLK_HZ, 1_640_000);
   localparam int unsigned T_1U   = cyc_of(CLK_HZ, 1_000);
   localparam int unsigned T_E    = cyc_of(CLK_HZ, 240);
   localparam int unsigned CW     = $clog2(T_PWR + 1);
   localparam int unsigned CLW    = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [2:0] {StPwrup, StInit, StConfig, StAddr, StChar} main_e;
   typedef enum logic [1:0] {PhSetup, PhEhigh, PhHold, PhGap} phase_e;

   main_e          main_q, main_d;
   phase_e         ph_q, ph_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [1:0]     step_q, step_d;
   logic           lo_q, lo_d;
   logic           row_q, row_d;
   logic [CLW-1:0] col_q, col_d;
   logic [7:0]     byte_q, byte_d;
   logic           ready_q, ready_d;
   logic [7:0]     buf_q [NCHR];
   int unsigned    gap;
   logic           start;
   logic [AW-1:0]  rd_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NCHR; i++) buf_q[i] <= 8'h20;
      end else if (clr) begin
         for (int unsigned i = 0; i < NCHR; i++) buf_q[i] <= 8'h20;
      end else if (wr_en && (32'(wr_addr) < NCHR)) begin
         buf_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      gap = T_40U;
      if (main_q == StInit) begin
         case (step_q)
            2'd0:    gap = T_4M1;
            2'd1:    gap = T_100U;
            default: gap = T_40U;
         endcase
      end else if (!lo_q) begin
         gap = T_1U;
      end else if (main_q == StConfig && step_q == 2'd3) begin
         gap = T_CLR;
      end
   end

   always_comb begin
      main_d  = main_q;
      ph_d    = ph_q;
      cnt_d   = cnt_q;
      step_d  = step_q;
      lo_d    = lo_q;
      row_d   = row_q;
      col_d   = col_q;
      byte_d  = byte_q;
      ready_d = ready_q;
      start   = 1'b0;
      rd_idx  = '0;

      if (main_q == StPwrup) begin
         if (cnt_q == CW'(T_PWR - 1)) begin
            main_d = StInit;
            step_d = 2'd0;
            ph_d   = PhSetup;
            cnt_d  = '0;
            start  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         unique case (ph_q)
            PhSetup: begin
               if (cnt_q == CW'(1)) begin
                  ph_d  = PhEhigh;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            PhEhigh: begin
               if (cnt_q == CW'(T_E - 1)) begin
                  ph_d  = PhHold;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            PhHold: begin
               ph_d  = PhGap;
               cnt_d = '0;
            end
            PhGap: begin
               if (cnt_q == CW'(gap - 1)) begin
                  ph_d  = PhSetup;
                  cnt_d = '0;
                  if (main_q == StInit) begin
                     start = 1'b1;
                     if (step_q == 2'd3) begin
                        main_d = StConfig;
                        step_d = 2'd0;
                     end else begin
                        step_d = step_q + 2'd1;
                     end
                  end else if (!lo_q) begin
                     lo_d = 1'b1;
                  end else begin
                     lo_d  = 1'b0;
                     start = 1'b1;
                     case (main_q)
                        StConfig: begin
                           if (step_q == 2'd3) begin
                              main_d  = StAddr;
                              row_d   = 1'b0;
                              ready_d = 1'b1;
                           end else begin
                              step_d = step_q + 2'd1;
                           end
                        end
                        StAddr: begin
                           main_d = StChar;
                           col_d  = '0;
                        end
                        default: begin
                           if (col_q == CLW'(COLS - 1)) begin
                              main_d = StAddr;
                              row_d  = (ROWS > 1) ? ~row_q : 1'b0;
                           end else begin
                              col_d = col_q + CLW'(1);
                           end
                        end
                     endcase
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ph_d = PhSetup;
         endcase
      end

      // The byte is latched as the next upper-nibble SETUP begins.
      if (start) begin
         rd_idx = AW'(32'(row_d) * COLS + 32'(col_d));
         case (main_d)
            StInit:   byte_d = (step_d == 2'd3) ? 8'h20 : 8'h30;
            StConfig: begin
               case (step_d)
                  2'd0:    byte_d = (ROWS == 2) ? 8'h28 : 8'h20;
                  2'd1:    byte_d = 8'h06;
                  2'd2:    byte_d = 8'h08 | {5'b0, DISP_DCB};
                  default: byte_d = 8'h01;
               endcase
            end
            StAddr:   byte_d = {1'b1, row_d, 6'b0};
            StChar:   byte_d = buf_q[rd_idx];
            default:  byte_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q  <= StPwrup;
         ph_q    <= PhSetup;
         cnt_q   <= '0;
         step_q  <= 2'd0;
         lo_q    <= 1'b0;
         row_q   <= 1'b0;
         col_q   <= '0;
         byte_q  <= 8'h00;
         ready_q <= 1'b0;
      end else begin
         main_q  <= main_d;
         ph_q    <= ph_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         lo_q    <= lo_d;
         row_q   <= row_d;
         col_q   <= col_d;
         byte_q  <= byte_d;
         ready_q <= ready_d;
      end
   end

   assign sf_e   = 1'b1;
   assign lcd_rw = 1'b0;
   assign lcd_e  = (main_q != StPwrup) && (ph_q == PhEhigh);
   assign lcd_rs = (main_q == StChar);
   assign lcd_db = lo_q ? byte_q[3:0] : byte_q[7:4];
   assign ready  = ready_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed bench for lcd_text_driver at 1 MHz with a 2 x 12 display; decodes LCD
// nibbles from the pins and compares them with hand-computed sequences.
module tb_lcd_text_driver;

   localparam int unsigned COLS  = 12;
   localparam int unsigned ROWS  = 2;
   localparam int unsigned NCHR  = 24;
   localparam int unsigned AW    = 5;
   // Cycle counts at 1 MHz.
   localparam int unsigned T_PWR = 15000;
   localparam int unsigned T_CLR = 1640;
   localparam int unsigned T_E   = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [7:0]    wr_data = '0;
   logic          clr = 1'b0;
   logic          ready, sf_e, lcd_e, lcd_rs, lcd_rw;
   logic [3:0]    lcd_db;

   lcd_text_driver #(
      .CLK_HZ   (1_000_000),
      .COLS     (COLS),
      .ROWS     (ROWS),
      .DISP_DCB (3'b100)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .clr     (clr),
      .ready   (ready),
      .sf_e    (sf_e),
      .lcd_e   (lcd_e),
      .lcd_rs  (lcd_rs),
      .lcd_rw  (lcd_rw),
      .lcd_db  (lcd_db)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  db;
      logic        rs;
      int unsigned rise;
      int unsigned fall;
   } nib_t;

   nib_t        nibs[$];
   nib_t        cur;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic        e_prev = 1'b0, rs_prev = 1'b0, rdy_seen = 1'b0;
   logic [3:0]  db_prev = '0;
   int unsigned ew = 0, rdy_cyc = 0, rel = 0;
   logic [7:0]  exp_chr [NCHR];

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Pin-level nibble decoder with setup/hold/width checks.
   always @(negedge clk) begin
      if (!rst_n) begin
         ew = 0;
         rdy_seen = 1'b0;
      end else begin
         if (lcd_e && !e_prev) begin
            chk("setup_db", lcd_db, db_prev);
            chk("setup_rs", lcd_rs, rs_prev);
            chk("rw_low", lcd_rw, 0);
            cur.db = lcd_db;
            cur.rs = lcd_rs;
            cur.rise = cyc;
            ew = 0;
         end
         if (lcd_e) ew++;
         if (!lcd_e && e_prev) begin
            chk("ehigh_len", ew, T_E);
            chk("hold_db", lcd_db, cur.db);
            chk("hold_rs", lcd_rs, cur.rs);
            cur.fall = cyc;
            nibs.push_back(cur);
         end
         if (ready && !rdy_seen) begin
            rdy_seen = 1'b1;
            rdy_cyc = cyc;
         end
      end
      e_prev = rst_n ? lcd_e : 1'b0;
      db_prev = lcd_db;
      rs_prev = lcd_rs;
   end

   task automatic wait_nibs(input int unsigned n, input int unsigned budget);
      int unsigned k = 0;
      while (nibs.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (nibs.size() < n) chk("nibble_timeout", nibs.size(), n);
   endtask

   function automatic logic [8:0] nib_byte(input int unsigned i);
      return {nibs[i].rs, nibs[i].db, nibs[i+1].db};
   endfunction

   task automatic do_wr(input logic [AW-1:0] a, input logic [7:0] d, input logic c);
      @(negedge clk);
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = d;
      clr = c;
      @(negedge clk);
      wr_en = 1'b0;
      clr = 1'b0;
   endtask

   task automatic check_frame(input int unsigned base, input string tag);
      for (int r = 0; r < ROWS; r++) begin
         int unsigned idx = base + r * (2 * (COLS + 1));
         chk($sformatf("%s_addr_r%0d", tag, r), nib_byte(idx), (r == 0) ? 9'h080 : 9'h0C0);
         for (int c = 0; c < COLS; c++)
            chk($sformatf("%s_r%0d_c%0d", tag, r, c), nib_byte(idx + 2 + 2 * c),
                {1'b1, exp_chr[r * COLS + c]});
      end
   endtask

   initial begin
      logic [7:0] cfg [4];
      int unsigned init_db [4];
      int unsigned init_gap [4];
      int unsigned k;
      cfg = '{8'h28, 8'h06, 8'h0C, 8'h01};
      init_db = '{3, 3, 3, 2};
      init_gap = '{4103, 103, 43, 43};

      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sf_e", sf_e, 1);
      chk("rst_lcd_e", lcd_e, 0);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_rw", lcd_rw, 0);
      chk("rst_db", lcd_db, 0);
      chk("rst_ready", ready, 0);

      nibs.delete();
      rst_n = 1'b1;
      rel = cyc;
      // Writes while ready=0; addresses 24 and 28 are out of range.
      do_wr(5'd0, 8'h48, 1'b0);
      do_wr(5'd12, 8'h56, 1'b0);
      do_wr(5'd24, 8'h99, 1'b0);
      do_wr(5'd28, 8'h77, 1'b0);

      wait_nibs(4, 25000);
      chk("ready_during_init", ready, 0);
      chk("first_rise", nibs[0].rise - rel, T_PWR + 2);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("init%0d_db", i), {nibs[i].rs, nibs[i].db}, init_db[i]);
      end

      wait_nibs(12, 5000);
      for (int i = 0; i < 4; i++)
         chk($sformatf("init%0d_gap", i), nibs[i+1].rise - nibs[i].fall, init_gap[i]);
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("cfg%0d", b), nib_byte(4 + 2 * b), {1'b0, cfg[b]});
         chk($sformatf("cfg%0d_nib_gap", b), nibs[5 + 2 * b].rise - nibs[4 + 2 * b].fall, 4);
         if (b < 3)
            chk($sformatf("cfg%0d_byte_gap", b), nibs[6 + 2 * b].rise - nibs[5 + 2 * b].fall, 43);
      end

      wait_nibs(13, 3000);
      chk("clear_gap", nibs[12].rise - nibs[11].fall, T_CLR + 3);
      chk("ready_rise", rdy_cyc - nibs[11].fall, T_CLR + 1);
      chk("ready_high", ready, 1);

      for (int i = 0; i < NCHR; i++) exp_chr[i] = 8'h20;
      exp_chr[0] = 8'h48;
      exp_chr[12] = 8'h56;
      wait_nibs(64, 5000);
      check_frame(12, "f1");

      // clr wins over a simultaneous write.
      do_wr(5'd3, 8'h41, 1'b1);
      for (int i = 0; i < NCHR; i++) exp_chr[i] = 8'h20;
      wait_nibs(116, 5000);
      check_frame(64, "f2");

      do_wr(5'd13, 8'h5A, 1'b0);
      do_wr(5'd24, 8'h99, 1'b0);
      exp_chr[13] = 8'h5A;
      wait_nibs(168, 5000);
      check_frame(116, "f3");

      // Reset mid character pulse.
      k = 0;
      while (k < 5000) begin
         @(posedge clk);
         #1;
         if (lcd_e && lcd_rs) break;
         k++;
      end
      chk("char_pulse_found", lcd_e & lcd_rs, 1);
      chk("ready_before_rst", ready, 1);
      rst_n = 1'b0;
      #1;
      chk("async_lcd_e", lcd_e, 0);
      chk("async_ready", ready, 0);
      chk("async_db", lcd_db, 0);
      chk("async_rs", lcd_rs, 0);
      repeat (2) @(negedge clk);
      nibs.delete();
      rst_n = 1'b1;
      rel = cyc;
      wait_nibs(1, T_PWR + 100);
      chk("restart_rise", nibs[0].rise - rel, T_PWR + 2);
      chk("restart_db", {nibs[0].rs, nibs[0].db}, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
